ro_scheduler: RTL and testbench

- Sequences the per-channel readout blocks onto the shared 2-bit tristate readout bus.
- Generates the divide-by-DIV frame clock (clk_64) and a frame-start pulse.
- Issues one-hot tristate enables, one channel at a time, with guard gaps so no two blocks ever drive the bus together.
- Sits between the external clock pin and the ro_block_N enable inputs; replaces ad-hoc per-block enable flops.

---
 rtl/ro_pkg.sv | 19 +
 rtl/ro_divider.sv | 45 ++++
 rtl/ro_scheduler.sv | 142 ++++++++++++++
 tb/tb_ro_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared types and defaults for the readout-bus scheduler.
package ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } ro_state_e;

    localparam int RO_NUM_CH = 8;
    localparam int RO_DIV    = 64;

    // Width of a channel index; never below one bit so a single-channel build still has a port.
    function automatic int ro_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_divider.sv
// Frame divider: div_cnt, frame clock, frame-start pulse and frame counter.
module ro_divider
    import ro_pkg::*;
#(
    parameter int DIV = RO_DIV
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       en,
    output logic       wrap,
    output logic       clk_64,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam int            DW   = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] cnt_nxt;

    // wrap marks the edge that opens a new frame; the scheduler acts on it in the same edge.
    assign wrap    = en && (div_cnt == LAST);
    assign cnt_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;

    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt     <= LAST;
            clk_64      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (!en) begin
            div_cnt     <= LAST;
            clk_64      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= cnt_nxt;
            clk_64      <= (cnt_nxt < HALF);
            frame_start <= (div_cnt == LAST);
            if (div_cnt == LAST)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/ro_scheduler.sv
// Time-slots the readout channels onto the shared tristate bus with guard gaps between drivers.
module ro_scheduler
    import ro_pkg::*;
#(
    parameter int  NUM_CH = RO_NUM_CH,
    parameter int  DIV    = RO_DIV,
    parameter int  SLOT   = 4,
    parameter int  GUARD  = 1,
    localparam int CH_W   = ro_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] ro_en,
    output logic [CH_W-1:0]   ch_idx,
    output logic              clk_64,
    output logic              frame_start,
    output logic              busy,
    output logic [7:0]        frame_cnt
);
    localparam int            GS_MAX = (GUARD > SLOT) ? GUARD : SLOT;
    localparam int            CW     = $clog2(GS_MAX + 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GUARD - 1);
    localparam logic [CW-1:0] S_LOAD = CW'(SLOT - 1);

    generate
        if (NUM_CH * (GUARD + SLOT) > DIV - 1) begin : g_chk_fit
            $fatal(1, "ro_scheduler: NUM_CH*(GUARD+SLOT) exceeds DIV-1");
        end
        if (DIV < 4 || (DIV % 2) != 0 || GUARD < 1 || SLOT < 1) begin : g_chk_par
            $fatal(1, "ro_scheduler: DIV must be even >= 4, GUARD and SLOT >= 1");
        end
    endgenerate

    logic wrap;

    ro_divider #(.DIV(DIV)) u_div (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .wrap        (wrap),
        .clk_64      (clk_64),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    ro_state_e         state, st_nxt;
    logic [CH_W-1:0]   cur_ch, ch_nxt, hit_ch;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NUM_CH-1:0] mask_q, srch, ro_en_nxt;
    logic              hit;
    int                lo;

    // At frame start the search runs on the incoming mask, since mask_q is loaded on that same edge.
    always_comb begin
        srch   = wrap ? ch_mask : mask_q;
        lo     = wrap ? 0 : int'(cur_ch) + 1;
        hit    = 1'b0;
        hit_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (srch[i] && i >= lo) begin
                hit    = 1'b1;
                hit_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        st_nxt  = state;
        ch_nxt  = cur_ch;
        cnt_nxt = cnt;
        if (!en) begin
            st_nxt  = ST_IDLE;
            ch_nxt  = '0;
            cnt_nxt = '0;
        end else if (wrap) begin
            ch_nxt  = hit_ch;
            cnt_nxt = G_LOAD;
            st_nxt  = hit ? ST_GUARD : ST_DONE;
        end else begin
            case (state)
                ST_GUARD: begin
                    if (cnt == '0) begin
                        st_nxt  = ST_DRIVE;
                        cnt_nxt = S_LOAD;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        if (hit) begin
                            st_nxt  = ST_GUARD;
                            ch_nxt  = hit_ch;
                            cnt_nxt = G_LOAD;
                        end else begin
                            st_nxt = ST_DONE;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ro_en_nxt = '0;
        if (st_nxt == ST_DRIVE)
            ro_en_nxt[ch_nxt] = 1'b1;
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= ST_IDLE;
            cur_ch <= '0;
            cnt    <= '0;
            mask_q <= '0;
            ro_en  <= '0;
            ch_idx <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= st_nxt;
            cur_ch <= ch_nxt;
            cnt    <= cnt_nxt;
            if (wrap)
                mask_q <= ch_mask;
            ro_en  <= ro_en_nxt;
            ch_idx <= (st_nxt == ST_DRIVE) ? ch_nxt : '0;
            busy   <= (st_nxt == ST_GUARD) || (st_nxt == ST_DRIVE);
        end
    end

`ifndef SYNTHESIS
    a_frame_in_idle: assert property (@(negedge clk) disable iff (!rstb)
        wrap |-> (state == ST_IDLE || state == ST_DONE));
`endif

endmodule

// File: tb/tb_ro_scheduler.sv
// Bench for ro_scheduler: frame-position reference model, directed pins and random traffic.
module tb_ro_scheduler;
    import ro_pkg::*;

    localparam int NUM_CH = 8;
    localparam int DIV    = 64;
    localparam int SLOT   = 4;
    localparam int GUARD  = 1;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              en = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [NUM_CH-1:0] ro_en;
    logic [CH_W-1:0]   ch_idx;
    logic              clk_64, frame_start, busy;
    logic [7:0]        frame_cnt;

    ro_scheduler #(.NUM_CH(NUM_CH), .DIV(DIV), .SLOT(SLOT), .GUARD(GUARD)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .ch_mask     (ch_mask),
        .ro_en       (ro_en),
        .ch_idx      (ch_idx),
        .clk_64      (clk_64),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: position inside the current frame and the mask captured at its start.
    bit          m_run  = 1'b0;
    int          m_pos  = 0;
    logic [7:0]  m_mask = '0;
    logic [7:0]  m_fcnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pos  = 0;
        m_mask = '0;
        m_fcnt = '0;
    endtask

    task automatic model_edge();
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run || m_pos == DIV - 1) begin
            m_run  = 1'b1;
            m_pos  = 0;
            m_mask = ch_mask;
            m_fcnt = m_fcnt + 8'd1;
        end else begin
            m_pos++;
        end
    endtask

    // The k-th enabled channel owns [k*(G+S)+G, k*(G+S)+G+S-1] of the frame.
    function automatic logic [NUM_CH-1:0] exp_ro_en();
        logic [NUM_CH-1:0] r;
        int k;
        r = '0;
        k = 0;
        if (m_run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_mask[i]) begin
                    if (m_pos >= k * (GUARD + SLOT) + GUARD && m_pos < (k + 1) * (GUARD + SLOT))
                        r[i] = 1'b1;
                    k++;
                end
            end
        end
        return r;
    endfunction

    function automatic int exp_idx();
        logic [NUM_CH-1:0] r;
        int idx;
        r   = exp_ro_en();
        idx = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (r[i]) idx = i;
        return idx;
    endfunction

    function automatic logic exp_busy();
        return m_run && (m_pos < $countones(m_mask) * (GUARD + SLOT));
    endfunction

    logic [NUM_CH-1:0] prev_ro_en = '0;

    always @(posedge clk) begin
        check("ro_en", 32'(ro_en), 32'(exp_ro_en()));
        check("ch_idx", 32'(ch_idx), 32'(exp_idx()));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("clk_64", 32'(clk_64), 32'(m_run && m_pos < DIV / 2));
        check("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        check("onehot0", 32'($countones(ro_en) <= 1), 32'd1);
        check("guard_gap", 32'(!(ro_en != 0 && prev_ro_en != 0 && ro_en != prev_ro_en)), 32'd1);
        prev_ro_en <= ro_en;
    end

    task automatic step(input logic e, input logic [7:0] m);
        en      = e;
        ch_mask = m;
        @(negedge clk);
        if (rstb) model_edge();
        @(posedge clk);
    endtask

    task automatic pulse_reset();
        #2;
        rstb = 1'b0;
        model_reset();
        #1;
        check("rst_ro_en", 32'(ro_en), 32'd0);
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        @(posedge clk);
        rstb = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        check("reset_ro_en", 32'(ro_en), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fcnt", 32'(frame_cnt), 32'd0);
        rstb = 1'b1;
        step(0, 8'hFF);

        // Full mask, one frame
        for (int c = 0; c < DIV; c++) begin
            step(1, 8'hFF);
            case (m_pos)
                0:  begin check("p_fs", 32'(frame_start), 1); check("p_fc1", 32'(frame_cnt), 1); end
                1:  check("p_ch0", 32'(ro_en), 32'h01);
                5:  check("p_gap5", 32'(ro_en), 32'h00);
                9:  check("p_ch1", 32'(ro_en), 32'h02);
                31: check("p_clk31", 32'(clk_64), 1);
                32: check("p_clk32", 32'(clk_64), 0);
                36: check("p_ch7", 32'(ro_en), 32'h80);
                39: check("p_busy39", 32'(busy), 1);
                40: check("p_busy40", 32'(busy), 0);
                default: ;
            endcase
        end

        // Sparse mask 1000_0101
        for (int c = 0; c < DIV; c++) begin
            step(1, 8'h85);
            case (m_pos)
                1:  check("s_idx0", 32'(ch_idx), 0);
                6:  begin check("s_ch2", 32'(ro_en), 32'h04); check("s_idx2", 32'(ch_idx), 2); end
                11: begin check("s_ch7", 32'(ro_en), 32'h80); check("s_idx7", 32'(ch_idx), 7); end
                14: check("s_busy14", 32'(busy), 1);
                15: check("s_busy15", 32'(busy), 0);
                default: ;
            endcase
        end

        // Empty mask, two frames
        for (int c = 0; c < 2 * DIV; c++) begin
            step(1, 8'h00);
            if (m_pos == 0) check("z_fs", 32'(frame_start), 1);
            if (m_pos == 3) check("z_busy", 32'(busy), 0);
        end
        check("z_fcnt", 32'(frame_cnt), 4);

        // Mask change mid-frame is deferred
        for (int c = 0; c < 2 * DIV; c++) begin
            step(1, (c >= 10) ? 8'h01 : 8'hFF);
            if (c == 36) check("m_ch7", 32'(ro_en), 32'h80);
            if (c == DIV + 1) check("m_ch0", 32'(ro_en), 32'h01);
            if (c == DIV + 5) check("m_busy", 32'(busy), 0);
        end

        // Drop en during ch1, then restart
        for (int c = 0; c < 8; c++) step(1, 8'hFF);
        check("e_ch1", 32'(ro_en), 32'h02);
        step(0, 8'hFF);
        check("e_ro_en", 32'(ro_en), 0);
        check("e_busy", 32'(busy), 0);
        check("e_fcnt", 32'(frame_cnt), 7);
        step(0, 8'hFF);
        step(1, 8'hFF);
        check("e_fcnt8", 32'(frame_cnt), 8);
        step(1, 8'hFF);
        check("e_ch0", 32'(ro_en), 32'h01);
        step(1, 8'hFF);
        pulse_reset();

        // Random traffic with occasional en drops and resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) pulse_reset();
            step($urandom_range(0, 99) != 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
